// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: 4-way round-robin arbiter with a rotating one-hot priority ring.
// Grants are registered, one-hot, and held for the requester's burst up to MAX_BURST cycles.
module ring_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CW = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       EN,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] GNT_ID,
    output logic       GNT_VALID,
    output logic       BURST_LAST
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t state, state_n;
    logic [3:0] pri, pri_n, gnt_n;
    logic [1:0] gnt_id_n, pri_idx, start, sel;
    logic [CW-1:0] cnt, cnt_n;
    logic at_cap, rel, found, hold, take;
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state  <= IDLE;
            GNT    <= 4'b0000;
            GNT_ID <= 2'd0;
            cnt    <= '0;
            pri    <= 4'b0001;
        end else begin
            state  <= state_n;
            GNT    <= gnt_n;
            GNT_ID <= gnt_id_n;
            cnt    <= cnt_n;
            pri    <= pri_n;
        end
    end
    always_comb begin
        pri_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (pri[i]) pri_idx = 2'(i);
    end
    assign at_cap = cnt == CW'(MAX_BURST);
    assign rel    = !REQ[GNT_ID] || at_cap;
    assign found  = |REQ;
    // On release the search starts one past the finishing requester, i.e. at the rotated PRI
    assign start  = state == GRANT ? GNT_ID + 2'd1 : pri_idx;
    always_comb begin
        sel = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (REQ[2'(start + 2'(k))]) sel = 2'(start + 2'(k));
    end
    always_comb
        state_n = (state == IDLE || rel) ? ((EN && found) ? GRANT : IDLE) : GRANT;
    always_comb begin
        hold     = state == GRANT && !rel;
        take     = (state == IDLE || rel) && EN && found;
        gnt_n    = hold ? GNT : take ? 4'b0001 << sel : 4'b0000;
        gnt_id_n = hold ? GNT_ID : take ? sel : 2'd0;
        cnt_n    = hold ? cnt + 1'b1 : take ? CW'(1) : '0;
        pri_n    = (state == GRANT && rel) ? 4'b0001 << (GNT_ID + 2'd1) : pri;
    end
    assign GNT_VALID  = |GNT;
    assign BURST_LAST = GNT_VALID && at_cap;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb_ring_rr_arbiter: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_ring_rr_arbiter;
    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       EN = 1'b0;
    logic [3:0] REQ = 4'b0000;
    logic [3:0] GNT;
    logic [1:0] GNT_ID;
    logic       GNT_VALID;
    logic       BURST_LAST;
    int checks = 0;
    int fails = 0;

    typedef struct {
        string      name;
        logic [3:0] gnt;
        logic       last;
        logic       chk;
        logic [3:0] pri;
    } exp_t;
    exp_t q[$];

    ring_rr_arbiter #(.MAX_BURST(4), .CW(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .REQ(REQ),
        .GNT(GNT), .GNT_ID(GNT_ID), .GNT_VALID(GNT_VALID), .BURST_LAST(BURST_LAST)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] enc(input logic [3:0] g);
        return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    endfunction

    task automatic step(input string name, input logic rn, input logic en, input logic [3:0] req,
                        input logic [3:0] gnt, input logic last, input logic chk, input logic [3:0] pri);
        exp_t e;
        RESET_N = rn;
        EN = en;
        REQ = req;
        @(posedge CLK);
        #1;
        e.name = name;
        e.gnt = gnt;
        e.last = last;
        e.chk = chk;
        e.pri = pri;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({GNT, GNT_ID, GNT_VALID, BURST_LAST} !== {e.gnt, enc(e.gnt), |e.gnt, e.last}) begin
                    fails++;
                    $display("FAIL %s: got gnt=%b id=%0d valid=%b last=%b, expected gnt=%b id=%0d valid=%b last=%b",
                             e.name, GNT, GNT_ID, GNT_VALID, BURST_LAST, e.gnt, enc(e.gnt), |e.gnt, e.last);
                end
                if (e.chk) begin
                    checks++;
                    if (dut.pri !== e.pri) begin
                        fails++;
                        $display("FAIL %s_pri: got pri=%b, expected pri=%b", e.name, dut.pri, e.pri);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        step("reset", 1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0001);
        step("reset", 1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 20; i++)
            step("rotate", 1'b1, 1'b1, 4'hF, 4'(4'b0001 << ((i / 4) % 4)), i % 4 == 3,
                 i > 0 && i % 4 == 0, 4'(4'b0001 << ((i / 4) % 4)));

        step("early_rst", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++)
            step("early_hold", 1'b1, 1'b1, 4'b0101, 4'b0001, 1'b0, 1'b0, 4'b0000);
        step("early_switch", 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 4'b0010);
        step("early_next", 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000);

        step("sole_rst", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001);
        for (int i = 1; i <= 10; i++)
            step("sole", 1'b1, 1'b1, 4'b0010, 4'b0010, i == 4 || i == 8, i == 5, 4'b0100);

        step("en_rst", 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("en_grant", 1'b1, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0000);
        step("en_hold", 1'b1, 1'b0, 4'hF, 4'b0100, 1'b0, 1'b0, 4'b0000);
        step("en_hold", 1'b1, 1'b0, 4'hF, 4'b0100, 1'b0, 1'b0, 4'b0000);
        step("en_last", 1'b1, 1'b0, 4'hF, 4'b0100, 1'b1, 1'b0, 4'b0000);
        step("en_idle", 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b1000);
        step("en_idle", 1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step("en_regrant", 1'b1, 1'b1, 4'hF, 4'b1000, 1'b0, 1'b0, 4'b0000);
        step("mid_hold", 1'b1, 1'b1, 4'hF, 4'b1000, 1'b0, 1'b0, 4'b0000);
        step("mid_reset", 1'b0, 1'b1, 4'hF, 4'b0000, 1'b0, 1'b1, 4'b0001);
        step("post_reset", 1'b1, 1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 4'b0000);
        step("post_hold", 1'b1, 1'b1, 4'b1001, 4'b0001, 1'b0, 1'b0, 4'b0000);

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among 4 requesters, using a rotating one-hot priority ring. Grants are one-hot and registered. A grant is held for the requester's burst, capped at MAX_BURST cycles, then priority rotates. It sits in front of the shared resource (e.g. a ring-sequenced datapath) and replaces fixed-order sequencing with fair, request-driven access.

Parameters:
MAX_BURST, 4, maximum consecutive grant cycles per grant; legal range 1..15.
CW, 4, width of the internal burst counter; must satisfy 2^CW > MAX_BURST.

Ports:
CLK  input  1  clock; all state updates on posedge.
RESET_N  input  1  synchronous, active-low reset, sampled on posedge CLK.
EN  input  1  arbitration enable; when low, no new grant is issued.
REQ  input  4  request vector; bit i = requester i; level-sensitive.
GNT  output  4  one-hot grant (registered); 4'b0000 when idle.
GNT_ID  output  2  binary index of the granted requester; 0 when idle.
GNT_VALID  output  1  high whenever GNT != 0.
BURST_LAST  output  1  high in the cycle the current grant's MAX_BURST-th cycle is presented.

Behaviour:
- Reset (RESET_N low at posedge): GNT=4'b0000, GNT_ID=0, GNT_VALID=0, BURST_LAST=0, priority pointer PRI=4'b0001, burst counter=0, state=IDLE. Reset overrides everything, including mid-burst: GNT drops after that edge.
- PRI is one-hot. Search order starts at PRI's bit and ascends circularly (3 wraps to 0).
- State IDLE:
  - At a posedge with EN=1 and REQ!=0, pick the first set REQ bit in search order and grant it. The selected requester is g.
  - After that edge: GNT=1<<g, counter=1, state=GRANT.
  - Latency: REQ sampled at edge n gives GNT visible after edge n (one cycle).
- State GRANT, evaluated at each posedge:
  - Release condition: REQ[g]==0, or counter==MAX_BURST.
  - If the release condition is false, hold GNT and increment the counter.
  - If the release condition is true, set PRI to the one-hot of (g+1) mod 4. Re-arbitrate in the same edge using the new PRI; requester g is eligible only if REQ[g] is still 1.
    - If EN=1 and a requester is found: grant it back-to-back with no idle cycle; counter=1.
    - Otherwise: GNT=0, state=IDLE.
- EN deasserted during GRANT: the current grant continues until its release condition; no re-grant follows; next state is IDLE.
- BURST_LAST = GNT_VALID and (counter==MAX_BURST). With MAX_BURST=1, BURST_LAST is high on every grant cycle.
- A sole continuous requester gets repeated MAX_BURST-cycle grants back-to-back. BURST_LAST pulses at the end of each grant.
- Requests arriving mid-grant only affect the next arbitration and never preempt the current grant.
- A REQ[g] drop is seen at the next posedge, so GNT stays high one cycle after the drop.
- GNT is never multi-hot. GNT_ID and GNT_VALID are registered together with GNT (same cycle).

Test Plan:
- Reset/idle: RESET_N=0 for 2 cycles, REQ=4'b1111 → GNT=0, GNT_VALID=0 throughout. Release reset with EN=1 → after the next edge, GNT=4'b0001, GNT_ID=0.
- Fair rotation: MAX_BURST=4, REQ=4'b1111 held, EN=1 → grants are req0 for 4 cycles, then req1, req2, req3, then req0 again, each 4 cycles with no gaps. BURST_LAST is high on cycles 4, 8, 12, 16.
- Early release: REQ=4'b0101, requester 0 drops REQ after 2 granted cycles → GNT=4'b0001 for 3 cycles (includes the one-cycle drop latency), then GNT=4'b0100 immediately on the next cycle.
- Sole requester: REQ=4'b0010 held 10 cycles → GNT=4'b0010 continuous. BURST_LAST pulses at grant cycles 4 and 8. PRI after the first release = 4'b0100.
- EN gating: grant active on req2, EN=0 at cycle 2 of the burst, REQ=4'b1111 → req2 finishes 4 cycles, then GNT=0 while EN=0. Re-raise EN → req3 granted first.
- Mid-burst reset: RESET_N=0 while GNT=4'b1000 → GNT=0 after the edge, and PRI returns to 4'b0001. After reset release with REQ=4'b1001, req0 is granted first.
